// File: rtl/fetcher.sv
// ----------------------------------------------------------------------------
// fetcher
// ----------------------------------------------------------------------------
// Instruction fetch unit. On a start pulse in IDLE it issues exactly one read
// on an AXI-style split address/data channel pair and returns the fetched
// word together with its address. It then pulses `completed` for one cycle.
// Every output comes straight from a flop.
//
// Optional feature (compile-time macro FETCHER_ALIGN_CHECK_EN):
//   When this macro is defined, a start request whose pc_in is not word-aligned
//   issues no bus read. The fetcher completes on the next edge instead. It
//   flags `misaligned` and returns a NOP (addi x0,x0,0 = 32'h00000013).
//   When the macro is undefined, the `misaligned` port does not exist. Every
//   request is then issued with its address forced to word alignment.
//
// Ports
//   clk          in   system clock, rising edge
//   rstn         in   synchronous active-low reset
//   enabled      in   start-fetch pulse; only looked at while idle
//   pc_in[31:0]  in   fetch address, captured together with enabled
//   completed    out  one-cycle pulse: pc / instr_raw are valid
//   pc[31:0]     out  address of the last fetched instruction
//   instr_raw    out  last fetched instruction word
//   mem_araddr   out  read address
//   mem_arvalid  out  read address valid
//   mem_arready  in   memory accepts the address
//   mem_rdata    in   read data
//   mem_rvalid   in   read data valid
//   mem_rready   out  fetcher accepts read data
//   misaligned   out  (FETCHER_ALIGN_CHECK_EN only) last request was misaligned
// ----------------------------------------------------------------------------
module fetcher (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    input  logic [31:0] pc_in,
    output logic        completed,
    output logic [31:0] pc,
    output logic [31:0] instr_raw,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
`ifdef FETCHER_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic        mem_rready
);

    // RV32I canonical NOP, returned in place of a misaligned fetch.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] req_pc_q,    req_pc_d;     // pc_in frozen for the in-flight fetch
    logic        completed_q, completed_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] araddr_q,    araddr_d;
    logic        arvalid_q,   arvalid_d;
    logic        rready_q,    rready_d;
`ifdef FETCHER_ALIGN_CHECK_EN
    logic        misaligned_q, misaligned_d;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        completed_d = 1'b0;          // pulse: low unless a fetch ends this edge
        pc_d        = pc_q;
        instr_d     = instr_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
`ifdef FETCHER_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                if (enabled) begin
`ifdef FETCHER_ALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        // Short-circuit: report and stay idle, no bus traffic.
                        completed_d  = 1'b1;
                        misaligned_d = 1'b1;
                        pc_d         = pc_in;
                        instr_d      = NOP_INSTR;
                    end else begin
                        req_pc_d  = pc_in;
                        araddr_d  = {pc_in[31:2], 2'b00};
                        arvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end
`else
                    // The low address bits are dropped. The full pc_in is kept
                    // and reported back as pc.
                    req_pc_d  = pc_in;
                    araddr_d  = {pc_in[31:2], 2'b00};
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
`endif
                end
            end

            S_ADDR: begin
                // araddr/arvalid keep their values until the slave accepts.
                if (arvalid_q && mem_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (mem_rvalid && rready_q) begin
                    instr_d     = mem_rdata;
                    pc_d        = req_pc_q;
                    rready_d    = 1'b0;
                    completed_d = 1'b1;
`ifdef FETCHER_ALIGN_CHECK_EN
                    misaligned_d = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a quiet idle bus.
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset wins over everything, including enabled.
    // A reset mid-fetch drops the transaction. Any later rvalid is then
    // ignored because the fetcher is back in IDLE with rready low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            req_pc_q    <= 32'h0;
            completed_q <= 1'b0;
            pc_q        <= 32'h0;
            instr_q     <= 32'h0;
            araddr_q    <= 32'h0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef FETCHER_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            completed_q <= completed_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`ifdef FETCHER_ALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign completed   = completed_q;
    assign pc          = pc_q;
    assign instr_raw   = instr_q;
    assign mem_araddr  = araddr_q;
    assign mem_arvalid = arvalid_q;
    assign mem_rready  = rready_q;
`ifdef FETCHER_ALIGN_CHECK_EN
    assign misaligned  = misaligned_q;
`endif

endmodule

// File: tb/tb_fetcher.sv
// ----------------------------------------------------------------------------
// tb_fetcher
// ----------------------------------------------------------------------------
// Self-checking bench for fetcher. A transaction-level reference model keeps
// one "outstanding request" record: whether a request is open, whether its
// address has been accepted, and its pc. It also keeps the last results
// returned. From these it predicts every output after each clock edge.
// The bench runs directed scenarios first and then randomized traffic with
// $urandom. It prints one line per completed fetch.
// ----------------------------------------------------------------------------
module tb_fetcher;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    logic [31:0] pc_in;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] instr_raw;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rready;
`ifdef FETCHER_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    fetcher dut (
        .clk         (clk),
        .rstn        (rstn),
        .enabled     (enabled),
        .pc_in       (pc_in),
        .completed   (completed),
        .pc          (pc),
        .instr_raw   (instr_raw),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
`ifdef FETCHER_ALIGN_CHECK_EN
        .misaligned  (misaligned),
`endif
        .mem_rready  (mem_rready)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: one open request at most, plus last results
    // ------------------------------------------------------------------
    bit          m_open;         // a request was accepted and has not finished
    bit          m_addr_taken;   // its address has been handed to memory
    logic [31:0] m_req_pc;
    logic [31:0] m_req_addr;
    bit          m_done_pulse;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_misaligned;
    int          m_ar_count  = 0; // expected address handshakes
    int          m_fetches   = 0; // expected completions
    int          obs_ar_count = 0;
    int          obs_fetches  = 0;

    task automatic model_edge(input bit rst_n_i, input bit en_i,
                              input logic [31:0] pc_i, input bit arr_i,
                              input bit rv_i, input logic [31:0] rd_i);
        m_done_pulse = 0;
        if (!rst_n_i) begin
            m_open       = 0;
            m_addr_taken = 0;
            m_req_addr   = 32'h0;
            m_pc         = 32'h0;
            m_instr      = 32'h0;
            m_misaligned = 0;
        end else if (!m_open) begin
            if (en_i) begin
`ifdef FETCHER_ALIGN_CHECK_EN
                if (pc_i % 4 != 0) begin
                    m_done_pulse = 1;
                    m_misaligned = 1;
                    m_pc         = pc_i;
                    m_instr      = 32'h0000_0013;
                    m_fetches++;
                end else begin
                    m_open = 1; m_addr_taken = 0;
                    m_req_pc = pc_i; m_req_addr = pc_i - (pc_i % 4);
                end
`else
                m_open = 1; m_addr_taken = 0;
                m_req_pc = pc_i; m_req_addr = pc_i - (pc_i % 4);
`endif
            end
        end else if (!m_addr_taken) begin
            if (arr_i) begin
                m_addr_taken = 1;
                m_ar_count++;
            end
        end else if (rv_i) begin
            m_open       = 0;
            m_done_pulse = 1;
            m_pc         = m_req_pc;
            m_instr      = rd_i;
            m_misaligned = 0;
            m_fetches++;
        end
    endtask

    task automatic compare_all();
        check_value("completed",   {31'h0, completed},   {31'h0, m_done_pulse});
        check_value("arvalid",     {31'h0, mem_arvalid}, {31'h0, (m_open && !m_addr_taken)});
        check_value("rready",      {31'h0, mem_rready},  {31'h0, (m_open && m_addr_taken)});
        check_value("araddr",      mem_araddr, m_req_addr);
        check_value("pc",          pc,         m_pc);
        check_value("instr_raw",   instr_raw,  m_instr);
`ifdef FETCHER_ALIGN_CHECK_EN
        check_value("misaligned",  {31'h0, misaligned}, {31'h0, m_misaligned});
`endif
        if (completed) begin
            obs_fetches++;
            $display("fetch #%0d pc=0x%08h instr=0x%08h", obs_fetches, pc, instr_raw);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic drive_cycle(input bit rst_n_i, input bit en_i,
                               input logic [31:0] pc_i, input bit arr_i,
                               input bit rv_i, input logic [31:0] rd_i);
        rstn        = rst_n_i;
        enabled     = en_i;
        pc_in       = pc_i;
        mem_arready = arr_i;
        mem_rvalid  = rv_i;
        mem_rdata   = rd_i;
        #1;
        if (rst_n_i && mem_arvalid && arr_i) obs_ar_count++;
        @(posedge clk);
        model_edge(rst_n_i, en_i, pc_i, arr_i, rv_i, rd_i);
        #1;
        compare_all();
    endtask

    int burst_done;

    initial begin
        rstn = 1'b0; enabled = 1'b0; pc_in = 32'h0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset
        drive_cycle(0, 0, 32'h0, 0, 0, 32'h0);
        drive_cycle(0, 1, 32'h0000_0040, 1, 1, 32'h0);   // reset beats enabled
        check_value("reset_arvalid", {31'h0, mem_arvalid}, 32'h0);
        check_value("reset_pc", pc, 32'h0);

        // Minimum latency fetch: completed after the third edge
        drive_cycle(1, 1, 32'h0000_0100, 1, 1, 32'h00A0_0093);
        check_value("lat_araddr", mem_araddr, 32'h0000_0100);
        drive_cycle(1, 0, 32'h0, 1, 1, 32'h00A0_0093);
        check_value("lat_edge2_completed", {31'h0, completed}, 32'h0);
        drive_cycle(1, 0, 32'h0, 1, 1, 32'h00A0_0093);
        check_value("lat_edge3_completed", {31'h0, completed}, 32'h1);
        check_value("lat_instr", instr_raw, 32'h00A0_0093);
        check_value("lat_pc", pc, 32'h0000_0100);
        drive_cycle(1, 0, 32'h0, 0, 0, 32'h0);

        // Address stall, then delayed data; enabled and pc_in wiggle meanwhile
        drive_cycle(1, 1, 32'h0000_0200, 0, 1, 32'h1111_1111);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 1, $urandom, 0, 1, $urandom);
            check_value("stall_araddr", mem_araddr, 32'h0000_0200);
        end
        drive_cycle(1, 1, 32'h0000_0300, 1, 0, 32'h0);
        drive_cycle(1, 1, 32'h0000_0400, 0, 0, 32'h0);
        drive_cycle(1, 1, 32'h0000_0500, 0, 1, 32'hCAFE_F00D);
        check_value("stall_instr", instr_raw, 32'hCAFE_F00D);
        check_value("stall_pc", pc, 32'h0000_0200);
        drive_cycle(1, 0, 32'h0, 0, 0, 32'h0);

        // Back-to-back requests: one completion every third edge
        burst_done = obs_fetches;
        for (int i = 0; i < 12; i++)
            drive_cycle(1, 1, 32'h0000_1000 + 32'(i * 4), 1, 1, 32'hA000_0000 + 32'(i));
        check_value("burst_count", 32'(obs_fetches - burst_done), 32'd4);
        drive_cycle(1, 0, 32'h0, 1, 1, 32'h0);

        // Reset while waiting for data; late rvalid is ignored
        drive_cycle(0, 0, 32'h0, 0, 0, 32'h0);
        drive_cycle(1, 1, 32'h0000_0300, 1, 0, 32'h0);
        drive_cycle(1, 0, 32'h0, 1, 0, 32'h0);
        drive_cycle(0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 0, 32'h0, 0, 1, 32'hBAD0_BAD0);
        check_value("rst_mid_rready", {31'h0, mem_rready}, 32'h0);
        check_value("rst_mid_instr", instr_raw, 32'h0);

        // Misaligned start address
        drive_cycle(1, 1, 32'h0000_0102, 1, 1, 32'h1234_5678);
`ifdef FETCHER_ALIGN_CHECK_EN
        check_value("mis_completed", {31'h0, completed}, 32'h1);
        check_value("mis_flag", {31'h0, misaligned}, 32'h1);
        check_value("mis_arvalid", {31'h0, mem_arvalid}, 32'h0);
        check_value("mis_instr", instr_raw, 32'h0000_0013);
`else
        check_value("mis_araddr", mem_araddr, 32'h0000_0100);
        drive_cycle(1, 0, 32'h0, 1, 1, 32'h1234_5678);
        drive_cycle(1, 0, 32'h0, 1, 1, 32'h1234_5678);
        check_value("mis_instr", instr_raw, 32'h1234_5678);
        check_value("mis_pc", pc, 32'h0000_0102);
`endif
        drive_cycle(1, 0, 32'h0, 0, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            drive_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0), rpc,
                        ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom);
        end

        check_value("ar_handshakes", 32'(obs_ar_count), 32'(m_ar_count));
        check_value("fetch_count", 32'(obs_fetches), 32'(m_fetches));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rstn  input  1  reset, synchronous, active-low; clock clk.
REQ-003 enabled  input  1  start-fetch pulse from core controller; sampled only in IDLE.
REQ-004 completed  output  1  registered one-cycle pulse; instr_raw/pc valid for decoder.
REQ-005 pc_in  input  32  address of instruction to fetch; sampled with enabled.
REQ-006 pc  output  32  address of the fetched instruction; held until next completion.
REQ-007 instr_raw  output  32  fetched instruction word; held until next completion.
REQ-008 mem_araddr  output  32  instruction memory read address.
REQ-009 mem_arvalid  output  1  read address valid.
REQ-010 mem_arready  input  1  memory accepts address.
REQ-011 mem_rdata  input  32  read data.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rready  output  1  fetcher accepts data.
REQ-014 misaligned  output  1  pc_in[1:0]!=0 at fetch start; exists only with FETCHER_ALIGN_CHECK_EN.

Function
REQ-015 States: IDLE, ADDR, DATA; all outputs registered.
REQ-016 IDLE & enabled: latch pc_in, mem_araddr<=pc_in, mem_arvalid<=1, go ADDR.
REQ-017 IDLE & !enabled: hold; mem_arvalid=0, mem_rready=0, completed=0.
REQ-018 ADDR: mem_arvalid and mem_araddr held stable until mem_arvalid&mem_arready.
REQ-019 ADDR handshake edge: mem_arvalid<=0, mem_rready<=1, go DATA.
REQ-020 DATA & mem_rvalid & mem_rready: instr_raw<=mem_rdata, pc<=latched pc_in, mem_rready<=0, completed<=1, go IDLE.
REQ-021 completed high exactly one cycle per fetch; minimum latency enable-to-completed = 3 edges (arready and rvalid already high).
REQ-022 enabled asserted in ADDR or DATA ignored; no queuing; no second request issued.
REQ-023 mem_rvalid while in IDLE or ADDR ignored; no capture.
REQ-024 pc_in changes after the enable cycle have no effect on the in-flight fetch.
REQ-025 Exactly one read transaction per enable accepted in IDLE.

Reset
REQ-026 rstn=0 at clock edge: state<=IDLE, completed<=0, mem_arvalid<=0, mem_rready<=0, mem_araddr<=0, pc<=0, instr_raw<=0, misaligned<=0 (if present).
REQ-027 Reset mid-transaction (ADDR/DATA): abandon fetch, handshake signals low next edge, no completed pulse, late mem_rvalid after reset ignored.
REQ-028 rstn=0 takes priority over enabled in the same cycle.

Configuration
REQ-029 Macro FETCHER_ALIGN_CHECK_EN defined: IDLE & enabled & pc_in[1:0]!=0 -> no bus request; next edge completed<=1, misaligned<=1, pc<=pc_in, instr_raw<=32'h00000013, stay IDLE.
REQ-030 Macro defined, aligned fetch: misaligned<=0 on its completion.
REQ-031 Macro undefined: misaligned port absent; mem_araddr<={pc_in[31:2],2'b00}; every enable issues a bus read.

Verification
REQ-032 Reset then enabled=1, pc_in=0x00000100, arready=1, rvalid=1 rdata=0x00A00093 -> araddr=0x100, completed pulse at edge 3, instr_raw=0x00A00093, pc=0x100.
REQ-033 pc_in=0x200, arready low 4 cycles then high, rvalid 2 cycles after -> arvalid/araddr stable throughout, single completed pulse, instr_raw captured.
REQ-034 enabled held high continuously, memory always ready -> one completed every 3 cycles, one AR handshake per completion, none issued while busy.
REQ-035 rstn=0 during DATA, rvalid arrives after release -> no completed, rready=0, instr_raw unchanged (0).
REQ-036 FETCHER_ALIGN_CHECK_EN defined, pc_in=0x00000102 -> no arvalid, completed and misaligned high next cycle, instr_raw=0x00000013; undefined -> araddr=0x100, normal fetch.
